// File: rtl/std_mult_seq_pkg.sv
// Shared definitions for the sequential multiplier primitives.
// A pipelined variant is expected to reuse mult_state_t.
package std_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Bit-count width able to hold the value w.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/std_mult_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, answering a
// valid/ready enable handshake. The product is registered in out and is held.
//
// state | meaning
// IDLE  | waiting for valid; operands captured on acceptance
// BUSY  | adding shifted multiplicand for each multiplier bit
// DONE  | ready high until valid drops
module std_mult_seq
  import std_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             ready,
  output logic [WIDTH-1:0] out
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t      state, state_next;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_sum;
  logic             last_bit;

  assign acc_sum  = mplier[0] ? (acc + mcand) : acc;
  assign last_bit = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: if (valid) state_next = BUSY;
      BUSY: begin
        if (!valid)        state_next = IDLE;
        else if (last_bit) state_next = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (!valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          mcand  <= left;
          mplier <= right;
          acc    <= '0;
          count  <= '0;
        end
        BUSY: if (valid) begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // The final add lands in out on the same edge as the DONE transition.
          if (last_bit) out <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_std_mult_seq.sv
// Directed self-checking bench for std_mult_seq at WIDTH=32.
module tb_std_mult_seq;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk;
  logic             reset;
  logic             valid;
  logic [WIDTH-1:0] left, right;
  logic             ready;
  logic [WIDTH-1:0] out;

  int checks   = 0;
  int failures = 0;

  std_mult_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .left  (left),
    .right (right),
    .ready (ready),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise valid and count edges until ready (bounded). Operands are scrambled
  // after acceptance to show they are not re-sampled.
  task automatic go(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r, output int n);
    left  = l;
    right = r;
    valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        left  = ~l;
        right = ~r;
      end
    end while (!ready && n < 100);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    left  = '0;
    right = '0;
    repeat (2) step();
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", ready);
    end
    checks++;
    if (out !== '0) begin
      failures++;
      $display("FAIL reset_out got=%h exp=0", out);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int n;
    go(32'd7, 32'd6, n);
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", n, LAT);
    end
    checks++;
    if (out !== 32'd42) begin
      failures++;
      $display("FAIL basic_out got=%0d exp=42", out);
    end
    valid = 1'b0;
    step();
    checks++;
    if (ready !== 1'b0 || out !== 32'd42) begin
      failures++;
      $display("FAIL basic_drop ready=%b out=%0d exp ready=0 out=42", ready, out);
    end
  endtask

  task automatic test_abort_restart();
    int n;
    int bad = 0;
    left  = 32'd3;
    right = 32'd5;
    valid = 1'b1;
    repeat (10) step();
    valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready !== 1'b0 || out !== 32'd42) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_hold bad_cycles=%0d exp=0 (ready=%b out=%0d)", bad, ready, out);
    end
    go(32'd3, 32'd5, n);
    checks++;
    if (n !== LAT || out !== 32'd15) begin
      failures++;
      $display("FAIL restart latency=%0d out=%0d exp latency=%0d out=15", n, out, LAT);
    end
    valid = 1'b0;
    step();
  endtask

  task automatic test_done_hold();
    int n;
    int bad = 0;
    go(32'h0000_0100, 32'h0000_0010, n);
    checks++;
    if (n !== LAT || out !== 32'h0000_1000) begin
      failures++;
      $display("FAIL hold_result latency=%0d out=%h exp latency=%0d out=00001000", n, out, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (ready !== 1'b1 || out !== 32'h0000_1000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable bad_cycles=%0d exp=0", bad);
    end
    valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ready !== 1'b0 || out !== 32'h0000_1000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_release bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_wrap();
    int n;
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    checks++;
    if (n !== LAT || out !== 32'h0000_0001) begin
      failures++;
      $display("FAIL wrap latency=%0d out=%h exp latency=%0d out=00000001", n, out, LAT);
    end
    valid = 1'b0;
    step();
  endtask

  task automatic test_zero();
    int n;
    go(32'd0, 32'h1234_5678, n);
    checks++;
    if (n !== LAT || out !== 32'd0) begin
      failures++;
      $display("FAIL zero latency=%0d out=%h exp latency=%0d out=0", n, out, LAT);
    end
    valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    left  = 32'd11;
    right = 32'd13;
    valid = 1'b1;
    repeat (21) step();
    reset = 1'b1;
    valid = 1'b0;
    step();
    checks++;
    if (ready !== 1'b0 || out !== '0) begin
      failures++;
      $display("FAIL reset_mid ready=%b out=%h exp ready=0 out=0", ready, out);
    end
    reset = 1'b0;
    step();
    go(32'd9, 32'd9, n);
    checks++;
    if (n !== LAT || out !== 32'd81) begin
      failures++;
      $display("FAIL after_reset latency=%0d out=%0d exp latency=%0d out=81", n, out, LAT);
    end
    valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort_restart();
    test_done_hold();
    test_wrap();
    test_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
